iob_align_seq: RTL and testbench

Iterative mantissa-alignment sequencer for the floating-point adder datapath. It accepts a mantissa and a right-shift amount, then shifts the mantissa right by at most STEP bits per cycle, accumulating a sticky bit (OR of every bit shifted out) at each step. Results are returned with the final sticky through a valid/ready handshake. It lets the adder align operands with a narrow per-cycle shifter instead of a full-width single-cycle barrel shifter.

---
 rtl/iob_align_seq.sv | 96 +++++++++
 tb/tb_iob_align_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/iob_align_seq.sv
// Iterative mantissa aligner: shifts right by up to STEP bits per cycle and
// ORs every bit shifted out into a sticky flag, returned over valid/ready.
module iob_align_seq #(
    parameter int DATA_W  = 32,
    parameter int SHIFT_W = 6,
    parameter int STEP    = 8
) (
    input  logic               clk_i,
    input  logic               arst_n_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [DATA_W-1:0]  man_i,
    input  logic [SHIFT_W-1:0] shift_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [DATA_W-1:0]  man_o,
    output logic               sticky_o,
    output logic               busy_o
);

    localparam int REM_W = $clog2(DATA_W + 1);
    localparam logic [REM_W-1:0] DATA_W_R = REM_W'(DATA_W);
    localparam logic [REM_W-1:0] STEP_R   = REM_W'(STEP);
    localparam logic [DATA_W:0]  ONE_W    = (DATA_W + 1)'(1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state, state_nxt;
    logic [DATA_W-1:0]  man_r;
    logic [REM_W-1:0]   rem;
    logic               sticky_r;

    logic               accept;
    logic [REM_W-1:0]   sat_shift;
    logic [REM_W-1:0]   amt;
    logic [REM_W-1:0]   rem_nxt;
    logic [DATA_W:0]    mask;

    assign accept = in_valid_i & in_ready_o;

    // Mask is one bit wider than the mantissa so amt == DATA_W still yields all ones.
    always_comb begin
        if (32'(shift_i) >= 32'(DATA_W)) sat_shift = DATA_W_R;
        else                             sat_shift = REM_W'(shift_i);
        amt     = (rem < STEP_R) ? rem : STEP_R;
        rem_nxt = rem - amt;
        mask    = (ONE_W << amt) - ONE_W;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) state <= IDLE;
        else           state <= state_nxt;
    end

    // NOTE: every signal is given a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (sat_shift == '0) ? DONE : SHIFT;
            SHIFT:   if (rem_nxt == '0) state_nxt = DONE;
            DONE:    if (out_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = (state == IDLE);
        out_valid_o = (state == DONE);
        busy_o      = (state == SHIFT) || (state == DONE);
    end

    // NOTE: datapath registers are reset too, so outputs read zero straight
    // out of reset and after an aborted job.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            man_r    <= '0;
            rem      <= '0;
            sticky_r <= 1'b0;
        end else if (accept) begin
            man_r    <= man_i;
            rem      <= sat_shift;
            sticky_r <= 1'b0;
        end else if (state == SHIFT) begin
            sticky_r <= sticky_r | (|(man_r & mask[DATA_W-1:0]));
            man_r    <= man_r >> amt;
            rem      <= rem_nxt;
        end
    end

    assign man_o    = man_r;
    assign sticky_o = sticky_r;

endmodule

// File: tb/tb_iob_align_seq.sv
// Directed-vector and random bench for iob_align_seq (DATA_W=32, STEP=8).
module tb_iob_align_seq;

    localparam int DATA_W  = 32;
    localparam int SHIFT_W = 6;
    localparam int STEP    = 8;

    logic               clk = 1'b0;
    logic               arst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [DATA_W-1:0]  man_in = '0;
    logic [SHIFT_W-1:0] shift_in = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [DATA_W-1:0]  man_out;
    logic               sticky;
    logic               busy;

    int errors = 0;
    int checks = 0;

    iob_align_seq #(.DATA_W(DATA_W), .SHIFT_W(SHIFT_W), .STEP(STEP)) dut (
        .clk_i(clk), .arst_n_i(arst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .man_i(man_in), .shift_i(shift_in),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .man_o(man_out), .sticky_o(sticky), .busy_o(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] man;
        logic [5:0]  shift;
        logic [31:0] exp_man;
        logic        exp_sticky;
        int          exp_n;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present a request and hold it until accepted; returns on accept edge + 1.
    task automatic accept_job(input logic [31:0] m, input logic [5:0] s);
        int guard = 0;
        in_valid = 1'b1; man_in = m; shift_in = s;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        check("accept_timeout", 64'(guard >= 100), 64'(0));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid after acceptance, then compare result and pop it.
    task automatic finish_job(input string tag, input logic [31:0] em, input logic es,
                              input int en, input bit chk_lat);
        int cnt = 0;
        while (!out_valid && cnt < 100) begin
            @(posedge clk); #1; cnt++;
        end
        if (chk_lat) check({tag, "_latency"}, 64'(cnt), 64'(en));
        else         check({tag, "_timeout"}, 64'(cnt >= 100), 64'(0));
        check({tag, "_man"},    64'(man_out), 64'(em));
        check({tag, "_sticky"}, 64'(sticky),  64'(es));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        if (chk_lat) begin
            check({tag, "_ready_after_pop"}, 64'(in_ready),  64'(1));
            check({tag, "_valid_after_pop"}, 64'(out_valid), 64'(0));
        end
    endtask

    initial begin
        vecs[0] = '{32'h8000_0013, 6'd20, 32'h0000_0800, 1'b1, 3};
        vecs[1] = '{32'hDEAD_BEEF, 6'd0,  32'hDEAD_BEEF, 1'b0, 0};
        vecs[2] = '{32'hFFFF_0000, 6'd16, 32'h0000_FFFF, 1'b0, 2};
        vecs[3] = '{32'h0000_0001, 6'd63, 32'h0000_0000, 1'b1, 4};
        vecs[4] = '{32'h1234_5678, 6'd8,  32'h0012_3456, 1'b1, 1};
        vecs[5] = '{32'h8000_0000, 6'd31, 32'h0000_0001, 1'b0, 4};
        vecs[6] = '{32'hFFFF_FFFF, 6'd32, 32'h0000_0000, 1'b1, 4};
        vecs[7] = '{32'h0000_0003, 6'd1,  32'h0000_0001, 1'b1, 1};
        vecs[8] = '{32'h0000_0100, 6'd9,  32'h0000_0000, 1'b1, 2};

        // Reset values
        #2;
        check("rst_man",      64'(man_out),   64'(0));
        check("rst_sticky",   64'(sticky),    64'(0));
        check("rst_valid",    64'(out_valid), 64'(0));
        check("rst_busy",     64'(busy),      64'(0));
        check("rst_in_ready", 64'(in_ready),  64'(1));
        #10 arst_n = 1'b1;
        @(posedge clk); #1;

        // Multi-step remainder walk: 20 -> 12 -> 4 -> 0
        accept_job(32'h8000_0013, 6'd20);
        check("rem_0", 64'(dut.rem), 64'(20));
        for (int i = 0; i < 3; i++) begin
            check("walk_valid_low", 64'(out_valid), 64'(0));
            check("walk_busy", 64'(busy), 64'(1));
            @(posedge clk); #1;
            check("rem_step", 64'(dut.rem), 64'(i == 0 ? 12 : (i == 1 ? 4 : 0)));
        end
        finish_job("walk", 32'h0000_0800, 1'b1, 0, 1'b1);

        // Table-driven vectors
        for (int i = 0; i < 9; i++) begin
            accept_job(vecs[i].man, vecs[i].shift);
            finish_job($sformatf("vec%0d", i), vecs[i].exp_man, vecs[i].exp_sticky,
                       vecs[i].exp_n, 1'b1);
        end

        // Reset in the middle of SHIFT discards the job
        accept_job(32'h8000_0013, 6'd20);
        @(posedge clk); #2;
        arst_n = 1'b0;
        #1;
        check("arst_man",      64'(man_out),   64'(0));
        check("arst_sticky",   64'(sticky),    64'(0));
        check("arst_valid",    64'(out_valid), 64'(0));
        check("arst_busy",     64'(busy),      64'(0));
        check("arst_in_ready", 64'(in_ready),  64'(1));
        #3 arst_n = 1'b1;
        begin
            int seen = 0;
            for (int i = 0; i < 8; i++) begin
                @(posedge clk); #1;
                if (out_valid) seen++;
            end
            check("arst_no_result", 64'(seen), 64'(0));
        end

        // Backpressure in DONE with ignored requests
        accept_job(32'hA5A5_00FF, 6'd4);
        @(posedge clk); #1;
        check("bp_valid", 64'(out_valid), 64'(1));
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0); man_in = 32'h1111_1111; shift_in = 6'd0;
            @(posedge clk); #1;
            check("bp_man",      64'(man_out),   64'(32'h0A5A_500F));
            check("bp_sticky",   64'(sticky),    64'(1));
            check("bp_in_ready", 64'(in_ready),  64'(0));
            check("bp_hold",     64'(out_valid), 64'(1));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_ready_next", 64'(in_ready),  64'(1));
        check("bp_valid_fall", 64'(out_valid), 64'(0));

        // Random back-to-back jobs against a single-cycle shift model
        for (int j = 0; j < 1000; j++) begin
            logic [31:0] m;
            logic [5:0]  s;
            int          sat;
            logic [63:0] msk;
            m   = $urandom;
            s   = 6'($urandom_range(0, 63));
            sat = (int'(s) >= DATA_W) ? DATA_W : int'(s);
            msk = (64'd1 << sat) - 64'd1;
            accept_job(m, s);
            finish_job("rand", 32'(64'(m) >> sat), |(64'(m) & msk),
                       (sat + STEP - 1) / STEP, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
